// File: rtl/sysid_check_ctrl.sv
// Boot-time system-ID checker: reads the ID and timestamp words from the system-ID
// slave over Avalon-MM and compares them against the values this build expects.
module sysid_check_ctrl #(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1489946846,
    parameter bit          AUTO_START     = 1'b1,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        m_address,
    output logic        m_read,
    input  logic        m_waitrequest,
    input  logic [31:0] m_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_word,
    output logic [31:0] ts_word,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE, S_START_PEND, S_RD_ID, S_RD_TS, S_CHECK, S_DONE, S_ERR
    } state_t;

    localparam state_t         RST_STATE = AUTO_START ? S_START_PEND : S_IDLE;
    localparam int             CW        = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0]  CNT_LAST  = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic          r_id_ok;
    logic          r_ts_ok;
    logic          r_timeout;
    logic [31:0]   r_id_word;
    logic [31:0]   r_ts_word;
    logic          w_reading;
    logic          w_abort;
    logic          w_enter_rd_id;

    assign w_reading     = (r_state == S_RD_ID) || (r_state == S_RD_TS);
    // The stall that would push the counter to TIMEOUT_CYCLES ends the check instead.
    assign w_abort       = w_reading && m_waitrequest && (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST);
    assign w_enter_rd_id = (w_next == S_RD_ID) && (r_state != S_RD_ID);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= RST_STATE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: if (start) w_next = S_RD_ID;
            S_START_PEND:          w_next = S_RD_ID;
            S_RD_ID: begin
                if (w_abort)             w_next = S_ERR;
                else if (!m_waitrequest) w_next = S_RD_TS;
            end
            S_RD_TS: begin
                if (w_abort)             w_next = S_ERR;
                else if (!m_waitrequest) w_next = S_CHECK;
            end
            S_CHECK:               w_next = S_DONE;
            default:               w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_id_ok   <= 1'b0;
            r_ts_ok   <= 1'b0;
            r_timeout <= 1'b0;
            r_id_word <= '0;
            r_ts_word <= '0;
        end else if (w_enter_rd_id) begin
            // Captured words survive a restart; only status is cleared.
            r_cnt     <= '0;
            r_id_ok   <= 1'b0;
            r_ts_ok   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_RD_ID, S_RD_TS: begin
                    if (w_abort) begin
                        r_timeout <= 1'b1;
                        r_id_ok   <= 1'b0;
                        r_ts_ok   <= 1'b0;
                        r_cnt     <= '0;
                    end else if (m_waitrequest) begin
                        r_cnt <= r_cnt + CW'(1);
                    end else begin
                        r_cnt <= '0;
                        if (r_state == S_RD_ID) r_id_word <= m_readdata;
                        else                    r_ts_word <= m_readdata;
                    end
                end
                S_CHECK: begin
                    r_id_ok <= (r_id_word == EXPECTED_ID);
                    r_ts_ok <= (r_ts_word == EXPECTED_TS);
                end
                default: ;
            endcase
        end
    end

    assign m_read    = w_reading;
    assign m_address = (r_state == S_RD_TS);
    assign busy      = w_reading || (r_state == S_CHECK);
    assign done      = (r_state == S_DONE) || (r_state == S_ERR);
    assign pass      = (r_state == S_DONE) && r_id_ok && r_ts_ok;
    assign id_ok     = r_id_ok;
    assign ts_ok     = r_ts_ok;
    assign timeout   = r_timeout;
    assign id_word   = r_id_word;
    assign ts_word   = r_ts_word;
    assign dbg_state = r_state;

endmodule
